dac_spi_tx: RTL and testbench
=============================

// Module: dac_spi_tx
// PURPOSE
//   Output end of the filter chain. Takes each filtered sample yk, strobed by resultadolisto from fycpa200.
//   Converts it from signed two's complement to offset-binary code.
//   Shifts it out as a 16-bit SPI frame to a 12-bit serial DAC (DAC121S101 type): 4 mode bits 0000, then 12 data bits, MSB first.
//   Holds a one-deep pending buffer so a sample that arrives mid-frame is not lost.
// PARAMETERS
//   N         12  sample width of yk; same value as `N in constantes.h; must be >= DAC_BITS
//   DAC_BITS  12  DAC resolution
//   CLK_DIV   4   clk cycles per sclk half-period (1..255)
//   QUIET     4   clk cycles sync_n stays high between frames (>=1)
// PORTS
//   clk             in   1  system clock; single clock domain
//   reset           in   1  asynchronous, active-high reset
//   yk              in   N  signed filter output; valid while resultadolisto=1
//   resultadolisto  in   1  1-cycle strobe: yk valid, request a frame
//   sclk            out  1  SPI clock; idles high
//   sync_n          out  1  DAC frame select, active low
//   sdata           out  1  serial data; changes with sclk rising, DAC samples on sclk falling
//   busy            out  1  high from frame start until QUIET has ended
//   frame_done      out  1  1-cycle pulse on the cycle sync_n returns high
//   overrun         out  1  1-cycle pulse when a request overwrites a full pending slot
// BEHAVIOUR
//   Reset state (async, immediate): sclk=1, sync_n=1, sdata=0, busy=0, frame_done=0, overrun=0.
//     Pending slot empties, FSM goes to IDLE, all counters clear.
//   Sample-to-code conversion: code = {~yk[N-1], yk[N-2 -: DAC_BITS-1]}.
//     This keeps the top DAC_BITS bits of yk and inverts the MSB; no rounding.
//   Frame: shreg[15:0] = {4'b0000, code}; bit 15 is sent first.
//   Input request: every clk edge with resultadolisto=1 is one request.
//     Holding the strobe high therefore makes repeated requests.
//   FSM states: IDLE, SHIFT, QUIET_ST.
//   IDLE:
//     A request at edge t, or a pending slot already full, loads shreg from the request or the slot and clears the slot.
//     At edge t+1: sync_n=0, busy=1, sdata=shreg[15], sclk=1.
//     A new request on the same edge as a pending load goes into the slot.
//   SHIFT:
//     Each bit lasts 2*CLK_DIV clk cycles: CLK_DIV cycles with sclk=1, then CLK_DIV cycles with sclk=0.
//     At each bit boundary sclk rises and sdata moves to the next bit; the bit counter runs 15 down to 0.
//     After the low half of bit 0: sclk=1, sync_n=1, sdata=0, frame_done=1 for one cycle; go to QUIET_ST.
//     sync_n is low for exactly 32*CLK_DIV cycles.
//   QUIET_ST:
//     Counts QUIET cycles, then goes to IDLE with busy=0.
//     If the slot is full, the next frame starts on the following edge, same as the IDLE rule.
//   Request while busy (SHIFT or QUIET_ST):
//     Slot empty: converted code is stored in the slot.
//     Slot full: the slot is overwritten with the newest code and overrun pulses.
//     The frame in progress is never altered.
//   Latency: strobe in IDLE to first falling sclk edge = 1 + CLK_DIV cycles.
//   Minimum frame period = 32*CLK_DIV + QUIET + 1 cycles. With defaults that is 133 cycles.
//   Reset mid-frame:
//     Frame aborts at once and the partial frame is discarded; the DAC ignores frames with fewer than 16 edges.
//     The pending code is lost.
//   Counter widths: divider uses $clog2(CLK_DIV)+1 bits; the bit counter and the quiet counter are 4 bits plus what QUIET needs.
// STRUCTURE
//   Constants in constantes.h:
//     `N
//     `DAC_FRAME (16)
//     `DAC_MODE (4'b0000)
//     FSM state encodings as `define.
//   Sub-module sclk_tick_gen:
//     Divider with enable; emits a 1-cycle tick every CLK_DIV cycles.
//     Cleared when the FSM leaves SHIFT, so each frame starts phase-aligned.
//   Top level holds the FSM, the shift register, the pending slot and the output registers.
//   All outputs are registered.
// TESTING (N=12, CLK_DIV=4, QUIET=4)
//   1 Reset pulse with resultadolisto=0 -> sclk=1, sync_n=1, sdata=0, busy=0; no sclk activity for 200 cycles.
//   2 yk=12'h000 strobe -> next edge sync_n=0.
//     Bits on 16 falling edges = 0000_1000_0000_0000.
//     sync_n low 128 cycles, then frame_done pulse.
//   3 yk=12'h7FF -> data bits 0xFFF.
//     yk=12'h800 -> 0x000.
//     yk=12'hFFF -> 0x7FF.
//   4 yk=12'h123 strobe, then yk=12'h456 at cycle 40.
//     -> Frame 0x923; quiet 4 cycles; frame 0xC56 starts with no further strobe.
//     No overrun.
//   5 Strobes at cycles 0, 30, 60 with yk=1,2,3 -> overrun pulse at cycle 60.
//     Frames 0x801 then 0x803 are transmitted; 0x802 is never sent.
//   6 Assert reset during bit 7 of a frame -> immediately sync_n=1, sclk=1, busy=0.
//     Next strobe sends a complete 16-bit frame.

Source files
------------

// File: rtl/dac_spi_tx_pkg.sv
// Shared constants and FSM encoding for the DAC SPI transmitter.
// Frame layout: 4 mode bits followed by the DAC code, MSB first.
package dac_spi_tx_pkg;

   localparam int unsigned FRAME_W = 16;
   localparam int unsigned MODE_W  = 4;

   localparam logic [MODE_W-1:0] DAC_MODE = 4'b0000;
   localparam logic [3:0]        LAST_BIT = 4'd15;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      QUIET_ST = 2'd2
   } state_t;

endpackage

// File: rtl/sclk_tick_gen.sv
// Clock divider for the SPI bit timing.
// Emits a one-cycle tick every CLK_DIV cycles while enabled.
module sclk_tick_gen
   import dac_spi_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLK_DIV) + 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

   // Count while enabled; clear when disabled so every frame starts aligned.
   always_comb begin
      cnt_d = '0;
      if (en && !tick) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Divider state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises filtered samples to a 12-bit SPI DAC as 16-bit frames.
// One-deep pending slot catches samples that arrive mid-frame.
module dac_spi_tx
   import dac_spi_tx_pkg::*;
#(
   parameter int unsigned N        = 12,
   parameter int unsigned DAC_BITS = 12,
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned QUIET    = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] yk,
   input  logic         resultadolisto,
   output logic         sclk,
   output logic         sync_n,
   output logic         sdata,
   output logic         busy,
   output logic         frame_done,
   output logic         overrun
);

   localparam int unsigned QW = $clog2(QUIET) + 1;

   state_t              state_q, state_d;
   logic [FRAME_W-1:0]  shreg_q, shreg_d;
   logic [3:0]          bit_cnt_q, bit_cnt_d;
   logic                half_q, half_d;
   logic [QW-1:0]       quiet_cnt_q, quiet_cnt_d;
   logic [DAC_BITS-1:0] slot_q, slot_d;
   logic                slot_full_q, slot_full_d;
   logic                sclk_q, sclk_d;
   logic                sync_n_q, sync_n_d;
   logic                sdata_q, sdata_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                overrun_q, overrun_d;

   logic [DAC_BITS-1:0] code;
   logic                tick;
   logic                tick_en;
   logic                quiet_done;
   logic                load_ok;

   function automatic logic [FRAME_W-1:0] mk_frame(
      input logic [DAC_BITS-1:0] c
   );
      return {DAC_MODE, c};
   endfunction

   // Two's complement to offset binary: keep top bits, flip the sign.
   assign code = {~yk[N-1], yk[N-2 -: DAC_BITS-1]};

   // Divider only runs once the frame has actually started.
   assign tick_en = (state_q == SHIFT) && !sync_n_q;

   assign quiet_done = (state_q == QUIET_ST) &&
                       (quiet_cnt_q == QW'(QUIET - 1));

   // The quiet-end edge behaves exactly like an IDLE edge.
   assign load_ok = (state_q == IDLE) || quiet_done;

   sclk_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (tick_en),
      .tick  (tick)
   );

   // Next-state, shifter, pending slot and output register logic.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      half_d       = half_q;
      quiet_cnt_d  = quiet_cnt_q;
      slot_d       = slot_q;
      slot_full_d  = slot_full_q;
      sclk_d       = sclk_q;
      sync_n_d     = sync_n_q;
      sdata_d      = sdata_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      overrun_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
         end
         SHIFT: begin
            if (sync_n_q) begin
               sync_n_d  = 1'b0;
               busy_d    = 1'b1;
               sclk_d    = 1'b1;
               sdata_d   = shreg_q[FRAME_W-1];
               half_d    = 1'b0;
               bit_cnt_d = LAST_BIT;
            end else if (tick) begin
               if (!half_q) begin
                  sclk_d = 1'b0;
                  half_d = 1'b1;
               end else if (bit_cnt_q == 4'd0) begin
                  sclk_d       = 1'b1;
                  sync_n_d     = 1'b1;
                  sdata_d      = 1'b0;
                  frame_done_d = 1'b1;
                  quiet_cnt_d  = '0;
                  state_d      = QUIET_ST;
               end else begin
                  sclk_d    = 1'b1;
                  half_d    = 1'b0;
                  bit_cnt_d = bit_cnt_q - 4'd1;
                  sdata_d   = shreg_q[FRAME_W-2];
                  shreg_d   = shreg_q << 1;
               end
            end
         end
         QUIET_ST: begin
            if (quiet_done) begin
               quiet_cnt_d = '0;
            end else begin
               quiet_cnt_d = quiet_cnt_q + QW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load_ok) begin
         if (quiet_done) begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         if (slot_full_q) begin
            shreg_d     = mk_frame(slot_q);
            state_d     = SHIFT;
            slot_full_d = resultadolisto;
            if (resultadolisto) begin
               slot_d = code;
            end
         end else if (resultadolisto) begin
            shreg_d = mk_frame(code);
            state_d = SHIFT;
         end
      end else if (resultadolisto) begin
         slot_d      = code;
         slot_full_d = 1'b1;
         overrun_d   = slot_full_q;
      end
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         half_q       <= 1'b0;
         quiet_cnt_q  <= '0;
         slot_q       <= '0;
         slot_full_q  <= 1'b0;
         sclk_q       <= 1'b1;
         sync_n_q     <= 1'b1;
         sdata_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         half_q       <= half_d;
         quiet_cnt_q  <= quiet_cnt_d;
         slot_q       <= slot_d;
         slot_full_q  <= slot_full_d;
         sclk_q       <= sclk_d;
         sync_n_q     <= sync_n_d;
         sdata_q      <= sdata_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign sclk       = sclk_q;
   assign sync_n     = sync_n_q;
   assign sdata      = sdata_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx with N=12, CLK_DIV=4, QUIET=4.
// A passive monitor decodes frames on falling sclk edges.
module tb_dac_spi_tx;

   localparam int CD = 4;
   localparam int QT = 4;

   logic        clk;
   logic        reset;
   logic [11:0] yk;
   logic        rl;
   logic        sclk;
   logic        sync_n;
   logic        sdata;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   int vectors;
   int miscompares;
   int cyc;

   logic [15:0] frame_q[$];
   int          bits_q[$];
   int          low_q[$];
   int          rise_q[$];
   int          sfall_q[$];
   int          ffall_q[$];
   int          fall_total;
   int          fd_total;
   int          fd_cyc;
   int          ov_total;
   int          ov_cyc;

   dac_spi_tx #(
      .N        (12),
      .DAC_BITS (12),
      .CLK_DIV  (CD),
      .QUIET    (QT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .yk             (yk),
      .resultadolisto (rl),
      .sclk           (sclk),
      .sync_n         (sync_n),
      .sdata          (sdata),
      .busy           (busy),
      .frame_done     (frame_done),
      .overrun        (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "bench did not finish");
   end

   // Passive frame decoder, sampling on the falling clk edge.
   initial begin
      logic        p_sclk;
      logic        p_sync;
      logic [15:0] word;
      int          nbits;
      int          low;
      p_sclk = 1'b1;
      p_sync = 1'b1;
      word = '0;
      nbits = 0;
      low = 0;
      fall_total = 0;
      fd_total = 0;
      fd_cyc = -1;
      ov_total = 0;
      ov_cyc = -1;
      forever begin
         @(negedge clk);
         if (p_sync && !sync_n) begin
            word = '0;
            nbits = 0;
            low = 0;
            sfall_q.push_back(cyc);
         end
         if (!sync_n) low++;
         if (p_sclk && !sclk) begin
            fall_total++;
            if (!sync_n) begin
               word = {word[14:0], sdata};
               nbits++;
               if (nbits == 1) ffall_q.push_back(cyc);
            end
         end
         if (!p_sync && sync_n) begin
            frame_q.push_back(word);
            bits_q.push_back(nbits);
            low_q.push_back(low);
            rise_q.push_back(cyc);
         end
         if (frame_done) begin
            fd_total++;
            fd_cyc = cyc;
         end
         if (overrun) begin
            ov_total++;
            ov_cyc = cyc;
         end
         p_sclk = sclk;
         p_sync = sync_n;
      end
   end

   task automatic clr_q();
      frame_q.delete();
      bits_q.delete();
      low_q.delete();
      rise_q.delete();
      sfall_q.delete();
      ffall_q.delete();
   endtask

   task automatic wait_to(input int e);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < e);
   endtask

   task automatic strobe(input logic [11:0] v, output int s);
      @(posedge clk);
      #1;
      yk = v;
      rl = 1'b1;
      @(posedge clk);
      #1;
      rl = 1'b0;
      s = cyc;
   endtask

   task automatic strobe_at(input int e, input logic [11:0] v);
      wait_to(e - 1);
      yk = v;
      rl = 1'b1;
      @(posedge clk);
      #1;
      rl = 1'b0;
   endtask

   task automatic wait_frames(input int n, input string tag);
      int k;
      k = 0;
      while (frame_q.size() < n && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      vectors++;
      if (frame_q.size() < n) begin
         miscompares++;
         $display("FAIL %s_timeout frames=%0d need=%0d",
                  tag, frame_q.size(), n);
      end
   endtask

   task automatic test_reset();
      int base_f;
      int base_s;
      reset = 1'b1;
      rl = 1'b0;
      yk = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (sclk !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_sclk got=%b exp=1", sclk);
      end
      vectors++;
      if (sync_n !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_sync_n got=%b exp=1", sync_n);
      end
      vectors++;
      if (sdata !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_sdata got=%b exp=0", sdata);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_busy got=%b exp=0", busy);
      end
      vectors++;
      if ({frame_done, overrun} !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_pulses got=%b exp=00",
                  {frame_done, overrun});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      base_f = fall_total;
      base_s = sfall_q.size();
      repeat (200) @(posedge clk);
      #1;
      vectors++;
      if (fall_total != base_f || sfall_q.size() != base_s) begin
         miscompares++;
         $display("FAIL rst_quiet got_falls=%0d exp=%0d",
                  fall_total - base_f, 0);
      end
   endtask

   task automatic test_frame_zero();
      int s;
      int r;
      int fd0;
      clr_q();
      fd0 = fd_total;
      strobe(12'h000, s);
      @(negedge clk);
      vectors++;
      if (sync_n !== 1'b1) begin
         miscompares++;
         $display("FAIL z_sync_early got=%b exp=1", sync_n);
      end
      @(negedge clk);
      vectors++;
      if ({sync_n, busy, sclk, sdata} !== 4'b0110) begin
         miscompares++;
         $display("FAIL z_start got=%b exp=0110",
                  {sync_n, busy, sclk, sdata});
      end
      wait_frames(1, "z");
      if (frame_q.size() < 1) return;
      r = rise_q[0];
      vectors++;
      if (frame_q[0] !== 16'h0800) begin
         miscompares++;
         $display("FAIL z_word got=%h exp=0800", frame_q[0]);
      end
      vectors++;
      if (bits_q[0] != 16) begin
         miscompares++;
         $display("FAIL z_bits got=%0d exp=16", bits_q[0]);
      end
      vectors++;
      if (low_q[0] != 32 * CD) begin
         miscompares++;
         $display("FAIL z_low got=%0d exp=%0d", low_q[0], 32 * CD);
      end
      vectors++;
      if (ffall_q[0] != s + 1 + CD) begin
         miscompares++;
         $display("FAIL z_latency got=%0d exp=%0d",
                  ffall_q[0] - s, 1 + CD);
      end
      vectors++;
      if (r != s + 1 + 32 * CD) begin
         miscompares++;
         $display("FAIL z_rise got=%0d exp=%0d",
                  r - s, 1 + 32 * CD);
      end
      vectors++;
      if (fd_total != fd0 + 1 || fd_cyc != r) begin
         miscompares++;
         $display("FAIL z_done got=%0d@%0d exp=1@%0d",
                  fd_total - fd0, fd_cyc, r);
      end
      wait_to(r + QT - 1);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL z_busy_quiet got=%b exp=1", busy);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL z_busy_end got=%b exp=0", busy);
      end
   endtask

   task automatic test_codes();
      logic [11:0] ins[3];
      logic [15:0] exps[3];
      int s;
      ins[0] = 12'h7FF;
      exps[0] = 16'h0FFF;
      ins[1] = 12'h800;
      exps[1] = 16'h0000;
      ins[2] = 12'hFFF;
      exps[2] = 16'h07FF;
      for (int i = 0; i < 3; i++) begin
         clr_q();
         strobe(ins[i], s);
         wait_frames(1, "code");
         if (frame_q.size() > 0) begin
            vectors++;
            if (frame_q[0] !== exps[i] || bits_q[0] != 16) begin
               miscompares++;
               $display("FAIL code_%h got=%h/%0d exp=%h/16",
                        ins[i], frame_q[0], bits_q[0], exps[i]);
            end
         end
         repeat (QT + 4) @(posedge clk);
      end
   endtask

   task automatic test_pending();
      int s;
      int ov0;
      clr_q();
      ov0 = ov_total;
      strobe(12'h123, s);
      strobe_at(s + 40, 12'h456);
      wait_frames(2, "pend");
      if (frame_q.size() < 2) return;
      vectors++;
      if (frame_q[0] !== 16'h0923) begin
         miscompares++;
         $display("FAIL pend_f0 got=%h exp=0923", frame_q[0]);
      end
      vectors++;
      if (frame_q[1] !== 16'h0C56 || bits_q[1] != 16) begin
         miscompares++;
         $display("FAIL pend_f1 got=%h/%0d exp=0c56/16",
                  frame_q[1], bits_q[1]);
      end
      vectors++;
      if (sfall_q[1] != rise_q[0] + QT + 1) begin
         miscompares++;
         $display("FAIL pend_gap got=%0d exp=%0d",
                  sfall_q[1] - rise_q[0], QT + 1);
      end
      vectors++;
      if (ov_total != ov0) begin
         miscompares++;
         $display("FAIL pend_ovr got=%0d exp=0", ov_total - ov0);
      end
      repeat (QT + 4) @(posedge clk);
   endtask

   task automatic test_overrun();
      int s;
      int ov0;
      clr_q();
      ov0 = ov_total;
      strobe(12'h001, s);
      strobe_at(s + 30, 12'h002);
      strobe_at(s + 60, 12'h003);
      wait_frames(2, "ovr");
      repeat (300) @(posedge clk);
      #1;
      vectors++;
      if (ov_total != ov0 + 1 || ov_cyc != s + 60) begin
         miscompares++;
         $display("FAIL ovr_pulse got=%0d@%0d exp=1@%0d",
                  ov_total - ov0, ov_cyc - s, 60);
      end
      vectors++;
      if (frame_q.size() != 2) begin
         miscompares++;
         $display("FAIL ovr_count got=%0d exp=2", frame_q.size());
      end
      if (frame_q.size() < 2) return;
      vectors++;
      if (frame_q[0] !== 16'h0801 || frame_q[1] !== 16'h0803) begin
         miscompares++;
         $display("FAIL ovr_words got=%h,%h exp=0801,0803",
                  frame_q[0], frame_q[1]);
      end
   endtask

   task automatic test_reset_mid();
      int s;
      clr_q();
      strobe(12'h5A5, s);
      strobe_at(s + 10, 12'h111);
      wait_to(s + 70);
      vectors++;
      if (sync_n !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_inframe got=%b exp=0", sync_n);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if ({sclk, sync_n, busy, sdata} !== 4'b1100) begin
         miscompares++;
         $display("FAIL mid_abort got=%b exp=1100",
                  {sclk, sync_n, busy, sdata});
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      clr_q();
      repeat (200) @(posedge clk);
      #1;
      vectors++;
      if (sfall_q.size() != 0) begin
         miscompares++;
         $display("FAIL mid_pending_lost got=%0d exp=0",
                  sfall_q.size());
      end
      strobe(12'h5A5, s);
      wait_frames(1, "mid");
      if (frame_q.size() < 1) return;
      vectors++;
      if (frame_q[0] !== 16'h0DA5 || bits_q[0] != 16 ||
          low_q[0] != 32 * CD) begin
         miscompares++;
         $display("FAIL mid_refire got=%h/%0d/%0d exp=0da5/16/%0d",
                  frame_q[0], bits_q[0], low_q[0], 32 * CD);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b1;
      rl = 1'b0;
      yk = '0;
      test_reset();
      test_frame_zero();
      test_codes();
      test_pending();
      test_overrun();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
